// File: rtl/syndrome_gen.sv
// syndrome_gen -- five-qubit code syndrome generator.
//
// Accepts one Pauli error frame (err_x/err_z, bit q = qubit q) and emits
// three registered syndrome words, one per cycle, for the X, Y and Z
// parts of the error. The stabilizer generators are
// g1=XZZXI, g2=IXZZX, g3=XIXZZ, g4=ZXIXZ (leftmost letter = qubit 0).
//
// Handshake (valid/ready): a frame is taken on a rising CLK edge where
// err_valid && err_ready. err_ready is a registered output that is high
// in IDLE and EMIT_Z, so frames can stream back to back with no gaps.
// The output side has no backpressure: ancilla_valid marks a word for
// exactly one cycle.
//
// Ports
//   CLK           clock, rising edge
//   RST           synchronous active-high reset
//   err_x, err_z  X / Z components of the error frame
//   err_valid     frame offered
//   err_ready     frame can be accepted this cycle
//   ancilla       syndrome word, [3]=g1 .. [0]=g4
//   axis          0=X, 1=Y, 2=Z for the current word
//   ancilla_valid ancilla/axis hold a frame word
//   nz_count      saturating count of frames with any nonzero syndrome
//   dbg_state     current FSM state (IDLE=0, EMIT_X=1, EMIT_Y=2, EMIT_Z=3)

module syndrome_gen (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] err_x,
  input  logic [4:0] err_z,
  input  logic       err_valid,
  output logic       err_ready,
  output logic [3:0] ancilla,
  output logic [1:0] axis,
  output logic       ancilla_valid,
  output logic [7:0] nz_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_X = 2'd1,
    EMIT_Y = 2'd2,
    EMIT_Z = 2'd3
  } state_t;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  // Generators in symplectic form: gx[q] set for X or Y on qubit q,
  // gz[q] set for Z or Y on qubit q. Index 0 is g1.
  localparam logic [4:0] GEN_X [4] = '{5'b01001, 5'b10010, 5'b00101, 5'b01010};
  localparam logic [4:0] GEN_Z [4] = '{5'b00110, 5'b01100, 5'b11000, 5'b10001};

  state_t     state;
  logic [4:0] frame_x;
  logic [4:0] frame_z;

  // Syndrome word for one axis of a frame. Only qubits whose error part
  // equals that axis contribute. For single-qubit Paulis, "gi[q] != I and
  // gi[q] != P" is exactly the symplectic product gx&pz ^ gz&px.
  function automatic logic [3:0] syndrome(input logic [4:0] ex,
                                          input logic [4:0] ez,
                                          input logic [1:0] ax);
    logic [4:0] part;
    logic [4:0] px;
    logic [4:0] pz;
    logic [3:0] word;
    case (ax)
      AX_X:    begin part = ex & ~ez; px = '1; pz = '0; end
      AX_Y:    begin part = ex &  ez; px = '1; pz = '1; end
      default: begin part = ~ex & ez; px = '0; pz = '1; end
    endcase
    for (int i = 0; i < 4; i++) begin
      word[3-i] = ^(part & ((GEN_X[i] & pz) ^ (GEN_Z[i] & px)));
    end
    return word;
  endfunction

  logic       accept;
  logic [3:0] in_syn_x;
  logic [3:0] syn_x;
  logic [3:0] syn_y;
  logic [3:0] syn_z;
  logic       frame_nz;

  assign accept    = err_valid && err_ready;
  assign in_syn_x  = syndrome(err_x, err_z, AX_X);
  assign syn_x     = syndrome(frame_x, frame_z, AX_X);
  assign syn_y     = syndrome(frame_x, frame_z, AX_Y);
  assign syn_z     = syndrome(frame_x, frame_z, AX_Z);
  assign frame_nz  = (syn_x != 4'd0) || (syn_y != 4'd0) || (syn_z != 4'd0);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      frame_x       <= '0;
      frame_z       <= '0;
      ancilla       <= '0;
      axis          <= AX_X;
      ancilla_valid <= 1'b0;
      err_ready     <= 1'b1;
      nz_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // The X word comes straight from the inputs so it appears
            // on the cycle right after acceptance.
            frame_x       <= err_x;
            frame_z       <= err_z;
            ancilla       <= in_syn_x;
            axis          <= AX_X;
            ancilla_valid <= 1'b1;
            err_ready     <= 1'b0;
            state         <= EMIT_X;
          end
        end
        EMIT_X: begin
          ancilla       <= syn_y;
          axis          <= AX_Y;
          ancilla_valid <= 1'b1;
          err_ready     <= 1'b0;
          state         <= EMIT_Y;
        end
        EMIT_Y: begin
          ancilla       <= syn_z;
          axis          <= AX_Z;
          ancilla_valid <= 1'b1;
          err_ready     <= 1'b1;
          state         <= EMIT_Z;
        end
        EMIT_Z: begin
          // The frame being retired is still in the frame register here.
          if (frame_nz && (nz_count != 8'hFF)) begin
            nz_count <= nz_count + 8'd1;
          end
          if (accept) begin
            frame_x       <= err_x;
            frame_z       <= err_z;
            ancilla       <= in_syn_x;
            axis          <= AX_X;
            ancilla_valid <= 1'b1;
            err_ready     <= 1'b0;
            state         <= EMIT_X;
          end else begin
            ancilla       <= '0;
            axis          <= AX_X;
            ancilla_valid <= 1'b0;
            err_ready     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          ancilla       <= '0;
          axis          <= AX_X;
          ancilla_valid <= 1'b0;
          err_ready     <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
